// File: rtl/tank_sensor_scanner.sv
// -----------------------------------------------------------------------------
// tank_sensor_scanner
//
// Takes a snapshot of every tank sensor word at once, checks each one against
// its own low/high limits, and then presents the held values one channel at a
// time on a single output bus. A channel that is out of range on ALARM_COUNT
// consecutive snapshots raises a sticky alarm, which puts the block into an
// error mode where the bus shows ERR_CODE until clear_alarm is pulsed.
//
// Ports:
//   CLK          clock, every state update happens on its rising edge
//   reset        synchronous, active-high; has priority over everything
//   scan_en      request sampling/scanning
//   clear_alarm  clears alarms, violation counters and error mode
//   sensor_data  live sensor words, channel i at [i*DATA_W +: DATA_W]
//   thr_lo       per-channel low limit (same packing)
//   thr_hi       per-channel high limit (same packing)
//   out_data     currently presented value (registered)
//   out_ch       channel index of out_data (registered)
//   out_valid    out_data/out_ch meaningful (registered)
//   alarm        sticky per-channel alarm bits (registered)
//   error        high while in the ERROR state (registered)
//   scan_count   number of completed sweeps, wraps to 0 (registered)
// -----------------------------------------------------------------------------
module tank_sensor_scanner #(
    parameter int                DATA_W      = 8,
    parameter int                NUM_CH      = 4,
    parameter int                DWELL       = 2,
    parameter int                ALARM_COUNT = 3,
    parameter logic [DATA_W-1:0] ERR_CODE    = 8'hFF,
    parameter int                COUNT_W     = 8
) (
    input  logic                       CLK,
    input  logic                       reset,
    input  logic                       scan_en,
    input  logic                       clear_alarm,
    input  logic [NUM_CH*DATA_W-1:0]   sensor_data,
    input  logic [NUM_CH*DATA_W-1:0]   thr_lo,
    input  logic [NUM_CH*DATA_W-1:0]   thr_hi,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(NUM_CH)-1:0]  out_ch,
    output logic                       out_valid,
    output logic [NUM_CH-1:0]          alarm,
    output logic                       error,
    output logic [COUNT_W-1:0]         scan_count
);

    localparam int CH_W = $clog2(NUM_CH);
    localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int VC_W = $clog2(ALARM_COUNT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_SCAN,
        ST_ERROR
    } state_t;

    state_t              state_q, state_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [DW_W-1:0]     dwell_q, dwell_d;
    logic [DATA_W-1:0]   shadow_q [NUM_CH];
    logic [DATA_W-1:0]   shadow_d [NUM_CH];
    logic [VC_W-1:0]     viol_q   [NUM_CH];
    logic [VC_W-1:0]     viol_d   [NUM_CH];
    logic [NUM_CH-1:0]   alarm_q, alarm_d;
    logic [COUNT_W-1:0]  scan_count_q, scan_count_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [CH_W-1:0]     out_ch_q, out_ch_d;
    logic                out_valid_q, out_valid_d;
    logic                error_q, error_d;

    // Per-channel snapshot value and the violation count it would produce
    // if this cycle were the SAMPLE exit edge.
    logic [DATA_W-1:0]   sens_w     [NUM_CH];
    logic [VC_W-1:0]     viol_upd_w [NUM_CH];

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
            logic [DATA_W-1:0] lo_w;
            logic [DATA_W-1:0] hi_w;
            logic              out_of_range_w;

            assign sens_w[gi]     = sensor_data[gi*DATA_W +: DATA_W];
            assign lo_w           = thr_lo[gi*DATA_W +: DATA_W];
            assign hi_w           = thr_hi[gi*DATA_W +: DATA_W];
            // Values equal to either limit are in range.
            assign out_of_range_w = (sens_w[gi] < lo_w) || (sens_w[gi] > hi_w);
            assign viol_upd_w[gi] = !out_of_range_w ? '0 :
                                    (viol_q[gi] == VC_W'(ALARM_COUNT)) ? viol_q[gi] :
                                    viol_q[gi] + VC_W'(1);
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        dwell_d      = dwell_q;
        shadow_d     = shadow_q;
        viol_d       = viol_q;
        alarm_d      = alarm_q;
        scan_count_d = scan_count_q;

        case (state_q)
            ST_IDLE: begin
                if (scan_en) begin
                    state_d = ST_SAMPLE;
                end
            end

            ST_SAMPLE: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    shadow_d[i] = sens_w[i];
                    viol_d[i]   = viol_upd_w[i];
                    if (viol_upd_w[i] == VC_W'(ALARM_COUNT)) begin
                        alarm_d[i] = 1'b1;
                    end
                end
                // A clear on this same edge wins over a freshly raised alarm;
                // the clear itself is applied after the case statement.
                if ((|alarm_d) && !clear_alarm) begin
                    state_d = ST_ERROR;
                end else begin
                    state_d = ST_SCAN;
                    ch_d    = '0;
                    dwell_d = '0;
                end
            end

            ST_SCAN: begin
                if (dwell_q == DW_W'(DWELL - 1)) begin
                    dwell_d = '0;
                    if (ch_q == CH_W'(NUM_CH - 1)) begin
                        // Sweep finished; scan_en is only consulted here, so
                        // dropping it mid-sweep lets the sweep complete.
                        scan_count_d = scan_count_q + COUNT_W'(1);
                        ch_d         = '0;
                        state_d      = scan_en ? ST_SAMPLE : ST_IDLE;
                    end else begin
                        ch_d = ch_q + CH_W'(1);
                    end
                end else begin
                    dwell_d = dwell_q + DW_W'(1);
                end
            end

            ST_ERROR: begin
                if (clear_alarm) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (clear_alarm) begin
            alarm_d = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                viol_d[i] = '0;
            end
        end

        // Outputs are registered from the next state so they line up with the
        // state they describe (ch0 shows the cycle after SAMPLE).
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = 1'b0;
        error_d     = 1'b0;
        case (state_d)
            ST_SCAN: begin
                out_valid_d = 1'b1;
                out_data_d  = shadow_d[ch_d];
                out_ch_d    = ch_d;
            end
            ST_ERROR: begin
                out_valid_d = 1'b1;
                out_data_d  = ERR_CODE;
                out_ch_d    = '0;
                error_d     = 1'b1;
            end
            default: begin
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ch_q         <= '0;
            dwell_q      <= '0;
            alarm_q      <= '0;
            scan_count_q <= '0;
            out_data_q   <= '0;
            out_ch_q     <= '0;
            out_valid_q  <= 1'b0;
            error_q      <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= '0;
                viol_q[i]   <= '0;
            end
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            dwell_q      <= dwell_d;
            alarm_q      <= alarm_d;
            scan_count_q <= scan_count_d;
            out_data_q   <= out_data_d;
            out_ch_q     <= out_ch_d;
            out_valid_q  <= out_valid_d;
            error_q      <= error_d;
            shadow_q     <= shadow_d;
            viol_q       <= viol_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_ch     = out_ch_q;
    assign out_valid  = out_valid_q;
    assign alarm      = alarm_q;
    assign error      = error_q;
    assign scan_count = scan_count_q;

endmodule

// File: tb/tb_tank_sensor_scanner.sv
// -----------------------------------------------------------------------------
// tb_tank_sensor_scanner
//
// Directed bench for tank_sensor_scanner with NUM_CH=4, DWELL=2,
// ALARM_COUNT=3. Each scenario task drives stimulus and compares outputs
// against hand-computed values, sampling 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_tank_sensor_scanner;

    logic        CLK = 1'b0;
    logic        reset;
    logic        scan_en;
    logic        clear_alarm;
    logic [31:0] sensor_data;
    logic [31:0] thr_lo;
    logic [31:0] thr_hi;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic [3:0]  alarm;
    logic        error;
    logic [7:0]  scan_count;

    int checks   = 0;
    int failures = 0;

    tank_sensor_scanner #(
        .DATA_W      (8),
        .NUM_CH      (4),
        .DWELL       (2),
        .ALARM_COUNT (3),
        .ERR_CODE    (8'hFF),
        .COUNT_W     (8)
    ) dut (
        .CLK         (CLK),
        .reset       (reset),
        .scan_en     (scan_en),
        .clear_alarm (clear_alarm),
        .sensor_data (sensor_data),
        .thr_lo      (thr_lo),
        .thr_hi      (thr_hi),
        .out_data    (out_data),
        .out_ch      (out_ch),
        .out_valid   (out_valid),
        .alarm       (alarm),
        .error       (error),
        .scan_count  (scan_count)
    );

    always #5 CLK = ~CLK;

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic set_ch(input int idx, input logic [7:0] val);
        sensor_data[idx*8 +: 8] = val;
    endtask

    task automatic do_reset();
        scan_en     = 1'b0;
        clear_alarm = 1'b0;
        sensor_data = {8'h70, 8'h38, 8'h1C, 8'h0E};
        thr_lo      = {4{8'h08}};
        thr_hi      = {4{8'h80}};
        reset       = 1'b1;
        run(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        scan_en     = 1'b1;
        clear_alarm = 1'b0;
        sensor_data = {8'h70, 8'h38, 8'h1C, 8'h0E};
        thr_lo      = {4{8'h08}};
        thr_hi      = {4{8'h80}};
        reset       = 1'b1;
        run(2);
        checks++;
        if (out_valid !== 1'b0 || error !== 1'b0 || alarm !== 4'b0000 ||
            scan_count !== 8'd0 || out_data !== 8'h00 || out_ch !== 2'd0) begin
            failures++;
            $display("FAIL reset_values: valid=%b err=%b alarm=%b cnt=%0d data=%h ch=%0d required 0/0/0000/0/00/0",
                     out_valid, error, alarm, scan_count, out_data, out_ch);
        end
        reset   = 1'b0;
        scan_en = 1'b0;
        run(2);
        checks++;
        if (out_valid !== 1'b0 || scan_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_idle: valid=%b cnt=%0d required 0/0", out_valid, scan_count);
        end
        $display("test_reset done");
    endtask

    task automatic test_single_sweep();
        logic [7:0] exp_v [4];
        exp_v = '{8'h0E, 8'h1C, 8'h38, 8'h70};
        do_reset();
        scan_en = 1'b1;
        run(1);
        scan_en = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL sweep_sample_valid: valid=%b required 0", out_valid);
        end
        run(1);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) run(1);
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_v[k/2] || out_ch !== 2'(k/2)) begin
                failures++;
                $display("FAIL sweep_word%0d: valid=%b data=%h ch=%0d required 1/%h/%0d",
                         k, out_valid, out_data, out_ch, exp_v[k/2], k/2);
            end
        end
        run(1);
        checks++;
        if (out_valid !== 1'b0 || scan_count !== 8'd1 || out_data !== 8'h70) begin
            failures++;
            $display("FAIL sweep_end: valid=%b cnt=%0d data=%h required 0/1/70",
                     out_valid, scan_count, out_data);
        end
        $display("test_single_sweep done");
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_v [4];
        do_reset();
        scan_en = 1'b1;
        run(2);
        exp_v = '{8'h0E, 8'h1C, 8'h38, 8'h70};
        for (int k = 0; k < 8; k++) begin
            if (k > 0) run(1);
            if (k == 1) set_ch(1, 8'h20);
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_v[k/2] || out_ch !== 2'(k/2)) begin
                failures++;
                $display("FAIL b2b_s1_word%0d: valid=%b data=%h ch=%0d required 1/%h/%0d",
                         k, out_valid, out_data, out_ch, exp_v[k/2], k/2);
            end
        end
        run(1);
        checks++;
        if (out_valid !== 1'b0 || scan_count !== 8'd1) begin
            failures++;
            $display("FAIL b2b_sample: valid=%b cnt=%0d required 0/1", out_valid, scan_count);
        end
        exp_v = '{8'h0E, 8'h20, 8'h38, 8'h70};
        run(1);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) run(1);
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_v[k/2] || out_ch !== 2'(k/2)) begin
                failures++;
                $display("FAIL b2b_s2_word%0d: valid=%b data=%h ch=%0d required 1/%h/%0d",
                         k, out_valid, out_data, out_ch, exp_v[k/2], k/2);
            end
        end
        scan_en = 1'b0;
        run(1);
        checks++;
        if (out_valid !== 1'b0 || scan_count !== 8'd2) begin
            failures++;
            $display("FAIL b2b_end: valid=%b cnt=%0d required 0/2", out_valid, scan_count);
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_alarm();
        do_reset();
        set_ch(2, 8'h90);
        scan_en = 1'b1;
        run(2);
        for (int s = 0; s < 2; s++) begin
            run(4);
            checks++;
            if (out_data !== 8'h90 || out_ch !== 2'd2 || error !== 1'b0) begin
                failures++;
                $display("FAIL alarm_s%0d_ch2: data=%h ch=%0d err=%b required 90/2/0",
                         s, out_data, out_ch, error);
            end
            run(4);
            checks++;
            if (alarm !== 4'b0000 || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL alarm_s%0d_sample: alarm=%b valid=%b required 0000/0",
                         s, alarm, out_valid);
            end
            if (s == 0) run(1);
        end
        run(1);
        checks++;
        if (alarm !== 4'b0100 || error !== 1'b1 || out_data !== 8'hFF ||
            out_valid !== 1'b1 || out_ch !== 2'd0 || scan_count !== 8'd2) begin
            failures++;
            $display("FAIL alarm_error: alarm=%b err=%b data=%h valid=%b ch=%0d cnt=%0d required 0100/1/FF/1/0/2",
                     alarm, error, out_data, out_valid, out_ch, scan_count);
        end
        run(12);
        checks++;
        if (error !== 1'b1 || out_data !== 8'hFF || scan_count !== 8'd2) begin
            failures++;
            $display("FAIL alarm_hold: err=%b data=%h cnt=%0d required 1/FF/2",
                     error, out_data, scan_count);
        end

        // Non-consecutive violations must not accumulate.
        do_reset();
        set_ch(2, 8'h90);
        scan_en = 1'b1;
        run(2);
        set_ch(2, 8'h38);
        run(9);
        set_ch(2, 8'h90);
        run(9);
        checks++;
        if (error !== 1'b0 || alarm !== 4'b0000 || out_valid !== 1'b1 || out_ch !== 2'd0) begin
            failures++;
            $display("FAIL alarm_nonconsec: err=%b alarm=%b valid=%b ch=%0d required 0/0000/1/0",
                     error, alarm, out_valid, out_ch);
        end
        run(4);
        checks++;
        if (out_data !== 8'h90 || out_ch !== 2'd2) begin
            failures++;
            $display("FAIL alarm_nonconsec_ch2: data=%h ch=%0d required 90/2", out_data, out_ch);
        end
        scan_en = 1'b0;
        $display("test_alarm done");
    endtask

    task automatic test_boundaries();
        do_reset();
        set_ch(0, 8'h08);
        set_ch(3, 8'h80);
        scan_en = 1'b1;
        run(2);
        for (int s = 0; s < 5; s++) begin
            checks++;
            if (alarm !== 4'b0000 || error !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h08) begin
                failures++;
                $display("FAIL bound_s%0d: alarm=%b err=%b valid=%b data=%h required 0000/0/1/08",
                         s, alarm, error, out_valid, out_data);
            end
            run(9);
        end
        scan_en = 1'b0;
        run(6);
        checks++;
        if (out_data !== 8'h80 || out_ch !== 2'd3) begin
            failures++;
            $display("FAIL bound_ch3: data=%h ch=%0d required 80/3", out_data, out_ch);
        end
        run(2);
        checks++;
        if (scan_count !== 8'd6 || out_valid !== 1'b0 || alarm !== 4'b0000) begin
            failures++;
            $display("FAIL bound_end: cnt=%0d valid=%b alarm=%b required 6/0/0000",
                     scan_count, out_valid, alarm);
        end
        $display("test_boundaries done");
    endtask

    task automatic test_clear_priority();
        do_reset();
        set_ch(2, 8'h90);
        scan_en = 1'b1;
        run(2);
        run(8);
        run(1);
        run(8);
        clear_alarm = 1'b1;
        run(1);
        clear_alarm = 1'b0;
        checks++;
        if (alarm !== 4'b0000 || error !== 1'b0 || out_valid !== 1'b1 ||
            out_ch !== 2'd0 || out_data !== 8'h0E) begin
            failures++;
            $display("FAIL clear_on_sample: alarm=%b err=%b valid=%b ch=%0d data=%h required 0000/0/1/0/0E",
                     alarm, error, out_valid, out_ch, out_data);
        end
        // Counters restarted from zero: two more violations stay below 3.
        run(9);
        run(9);
        checks++;
        if (alarm !== 4'b0000 || error !== 1'b0) begin
            failures++;
            $display("FAIL clear_counters: alarm=%b err=%b required 0000/0", alarm, error);
        end
        run(9);
        checks++;
        if (alarm !== 4'b0100 || error !== 1'b1) begin
            failures++;
            $display("FAIL clear_realarm: alarm=%b err=%b required 0100/1", alarm, error);
        end
        scan_en = 1'b0;
        $display("test_clear_priority done");
    endtask

    task automatic test_recovery();
        do_reset();
        set_ch(2, 8'h90);
        scan_en = 1'b1;
        run(20);
        checks++;
        if (error !== 1'b1) begin
            failures++;
            $display("FAIL recov_enter_error: err=%b required 1", error);
        end
        scan_en     = 1'b0;
        clear_alarm = 1'b1;
        set_ch(2, 8'h38);
        run(1);
        clear_alarm = 1'b0;
        checks++;
        if (error !== 1'b0 || alarm !== 4'b0000 || out_valid !== 1'b0 || out_data !== 8'hFF) begin
            failures++;
            $display("FAIL recov_idle: err=%b alarm=%b valid=%b data=%h required 0/0000/0/FF",
                     error, alarm, out_valid, out_data);
        end
        scan_en = 1'b1;
        run(1);
        scan_en = 1'b0;
        run(1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h0E || out_ch !== 2'd0) begin
            failures++;
            $display("FAIL recov_rescan: valid=%b data=%h ch=%0d required 1/0E/0",
                     out_valid, out_data, out_ch);
        end
        run(4);
        checks++;
        if (out_data !== 8'h38 || out_ch !== 2'd2) begin
            failures++;
            $display("FAIL recov_ch2: data=%h ch=%0d required 38/2", out_data, out_ch);
        end

        // Reset in the middle of the second sweep.
        do_reset();
        scan_en = 1'b1;
        run(2);
        run(9);
        run(3);
        checks++;
        if (scan_count !== 8'd1 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL recov_pre_reset: cnt=%0d valid=%b required 1/1", scan_count, out_valid);
        end
        reset = 1'b1;
        run(1);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0 ||
            error !== 1'b0 || alarm !== 4'b0000 || scan_count !== 8'd0) begin
            failures++;
            $display("FAIL recov_reset: valid=%b data=%h ch=%0d err=%b alarm=%b cnt=%0d required 0/00/0/0/0000/0",
                     out_valid, out_data, out_ch, error, alarm, scan_count);
        end
        reset   = 1'b0;
        scan_en = 1'b0;
        run(2);
        checks++;
        if (out_valid !== 1'b0 || scan_count !== 8'd0) begin
            failures++;
            $display("FAIL recov_after_reset: valid=%b cnt=%0d required 0/0", out_valid, scan_count);
        end
        $display("test_recovery done");
    endtask

    initial begin
        reset       = 1'b1;
        scan_en     = 1'b0;
        clear_alarm = 1'b0;
        sensor_data = '0;
        thr_lo      = '0;
        thr_hi      = '0;
        test_reset();
        test_single_sweep();
        test_back_to_back();
        test_alarm();
        test_boundaries();
        test_clear_priority();
        test_recovery();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
